key_schedule_ctrl: RTL and testbench
====================================

Name: key_schedule_ctrl

Overview:
Sequences the combinational Nk-word key-expansion step core over successive cycles to produce a full AES key schedule (AES-128/192/256, selected by Nk). It stores every expanded word in an internal word array and serves complete 128-bit round keys to the cipher/decipher round controllers over a registered read port. It sits between key load (host/top level) and the round datapath.

Parameters:
Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
Nr (localparam), Nk+6, number of cipher rounds.
NW (localparam), 4*(Nr+1), total schedule words: 44, 52 or 60.
S (localparam), ceil((NW-Nk)/Nk), expansion steps: 10, 8 or 7.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request expansion of key_in; sampled only in IDLE.
key_in  in  32*Nk  cipher key; word k at [32k+31:32k], byte 0 of each word in bits [7:0].
busy  out  1  high in LOAD and EXPAND.
done  out  1  one-cycle pulse when the schedule is complete.
key_valid  out  1  level; high from done until the next accepted start or reset.
rk_rd_idx  in  4  round-key index 0..Nr.
rk_rd_data  out  128  words 4*idx..4*idx+3, registered; same word/byte packing as key_in.

Behaviour:
- Reset (async assert, sync deassert by the integrator): state=IDLE; busy=0, done=0, key_valid=0, rk_rd_data=0, step counter=0, rcon index=0, word array cleared to 0.
- States: IDLE, LOAD, EXPAND, DONE.
- IDLE: start=1 -> latch key_in into w_reg, clear key_valid, go to LOAD. Otherwise remain.
- LOAD (1 cycle): write w_reg into words 0..Nk-1; step=0; go to EXPAND.
- EXPAND (S cycles): drive the step core with w_reg and rcon[step]. Word i of the core output is written to array word Nk*(step+1)+i only if that index < NW. Then w_reg<=core output, step++. After step S-1, go to DONE.
- DONE (1 cycle): done=1, key_valid=1, go to IDLE.
- Latency: start sampled at edge t -> done high during cycle t+2+S (Nk=4: t+12; Nk=6: t+10; Nk=8: t+9).
- Truncated final step: Nk=6 step 7 writes words 48..51 only; Nk=8 step 6 writes 56..59 only. The unused core outputs are discarded.
- rcon: 32-bit word with the constant in bits [7:0] and zero elsewhere. Sequence 01,02,04,08,10,20,40,80,1B,36, indexed by step. For Nk=8 the non-rcon SubWord on word 4 is handled inside the step core.
- start while busy or in DONE: ignored; no queuing.
- Read port: rk_rd_data <= array[4*idx+3 : 4*idx] on every clock edge, in every state, so read latency is 1 cycle.
  - idx > Nr returns 0.
  - Reads while key_valid=0 return whatever the array currently holds; consumers must gate on key_valid.
- A new start in IDLE overwrites the array progressively; key_valid stays 0 until the new done.
- Reset mid-operation: immediate return to IDLE with all state cleared; no done pulse.

Decomposition:
- Shared package aes_pkg holds:
  - the RCON constant array (10 x 8 bits);
  - functions nr_of(Nk) and nw_of(Nk);
  - the state enum ks_state_t {IDLE, LOAD, EXPAND, DONE}.
- One sub-module: the existing combinational expansion step core (generalExpandKey, parameter Nk), instantiated once.
- The word array stays inline as a flop array, to keep the 1-cycle read.

Test Plan:
1. Nk=4, key_in = FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c (packed per port convention), start pulse.
   - done exactly 12 cycles after start; busy high for 11 cycles.
   - Reading idx 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 (FIPS byte order); idx 0 equals the key.
2. Nk=6, key 000102...1617:
   - done at t+10;
   - idx 12 = a4970a331a78dc09c418c271e3a41d5d;
   - idx 13 reads 0.
3. Nk=8, key 000102...1e1f:
   - done at t+9;
   - idx 14 = 24fc79ccbf0979e9371ac23c6d68de36;
   - idx 1 = 101112131415161718191a1b1c1d1e1f.
4. Start re-pulsed during EXPAND with a different key_in.
   - Ignored; schedule matches the first key; single done pulse.
5. rst_n asserted in the 5th EXPAND cycle.
   - Outputs zero immediately; no done.
   - A subsequent start completes with the correct schedule and the same latency.
6. Back-to-back: a second start in the cycle after done, with a new key.
   - key_valid drops at the next edge and rises again at the second done.
   - The final idx 10 matches the second key.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, round constants and size helpers.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} ks_state_t;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int nw_of(input int nk);
        return 4 * (nk + 7);
    endfunction
endpackage

// File: rtl/generalExpandKey.sv
// generalExpandKey: one combinational AES key-expansion step producing the next Nk words.
module generalExpandKey #(
    parameter int Nk = 4
) (
    input  logic [32*Nk-1:0] w_in,
    input  logic [31:0]      rcon,
    output logic [32*Nk-1:0] w_out
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = '0;
        p = a;
        for (int i = 0; i < 8; i++) begin
            r = b[i] ? r ^ p : r;
            p = xtime(p);
        end
        return r;
    endfunction

    // Inverse as a^254 (squares a^2..a^128 multiplied together), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        w_out = '0;
        w_out[31:0] = w_in[31:0] ^ rcon ^ sub_word({w_in[32*Nk-25 -: 8], w_in[32*Nk-1 -: 24]});
        for (int i = 1; i < Nk; i++)
            w_out[32*i +: 32] = w_in[32*i +: 32] ^
                ((Nk == 8 && i == 4) ? sub_word(w_out[32*i-32 +: 32]) : w_out[32*i-32 +: 32]);
    end
endmodule

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: runs the expansion step core over successive cycles and
// serves stored 128-bit round keys through a registered read port.
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [32*Nk-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    input  logic [3:0]       rk_rd_idx,
    output logic [127:0]     rk_rd_data
);
    localparam int Nr = nr_of(Nk);
    localparam int NW = nw_of(Nk);
    localparam int S  = (NW - Nk + Nk - 1) / Nk;

    ks_state_t        state, state_nx;
    logic [32*Nk-1:0] w_reg, core_out;
    logic [3:0]       step;
    logic [31:0]      words [NW];
    logic [127:0]     rd_nx;
    logic [5:0]       rd_base;

    generalExpandKey #(.Nk(Nk)) u_core (
        .w_in (w_reg),
        .rcon ({24'h0, RCON[step]}),
        .w_out(core_out)
    );

    always_comb begin
        state_nx = state;
        busy     = state == LOAD || state == EXPAND;
        done     = state == DONE;
        if (state == IDLE && start) state_nx = LOAD;
        if (state == LOAD) state_nx = EXPAND;
        if (state == EXPAND && step == 4'(S - 1)) state_nx = DONE;
        if (state == DONE) state_nx = IDLE;
    end

    assign rd_base = {rk_rd_idx, 2'b00};

    always_comb begin
        rd_nx = '0;
        for (int k = 0; k < 4; k++)
            if (int'(rk_rd_idx) <= Nr) rd_nx[32*k +: 32] = words[rd_base + 6'(k)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            w_reg      <= '0;
            step       <= '0;
            key_valid  <= 1'b0;
            rk_rd_data <= '0;
            for (int j = 0; j < NW; j++) words[j] <= '0;
        end else begin
            state      <= state_nx;
            rk_rd_data <= rd_nx;
            if (state == IDLE && start) w_reg <= key_in;
            if (state == EXPAND) w_reg <= core_out;
            step <= state == LOAD ? 4'd0 : state == EXPAND ? step + 4'd1 : step;
            key_valid <= state_nx == DONE ? 1'b1 : (state == IDLE && start) ? 1'b0 : key_valid;
            // Words past NW from the final, truncated step are simply never written.
            for (int j = 0; j < NW; j++) begin
                if (state == LOAD && j < Nk) words[j] <= w_reg[32*(j%Nk) +: 32];
                if (state == EXPAND && j >= Nk && (j - Nk) / Nk == int'(step))
                    words[j] <= core_out[32*((j-Nk)%Nk) +: 32];
            end
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: scoreboard bench for Nk=4/6/8 against a FIPS-197 style reference model.
module tb_key_schedule_ctrl;
    localparam int NKS [3] = '{4, 6, 8};
    localparam int SS  [3] = '{10, 8, 7};
    localparam int NRS [3] = '{10, 12, 14};

    typedef struct {int s; int c;} dn_t;
    typedef struct {int s; int i; logic [127:0] e;} rd_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   st = '0;
    logic [255:0] key = '0;
    logic [3:0]   idx = '0;
    logic [2:0]   busy_o, done_o, kv_o;
    logic [127:0] rd_o [3];
    logic         rd_req = 1'b0;
    logic         rd_vld = 1'b0;
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;
    dn_t          done_q[$];
    rd_t          rd_q[$];
    logic [7:0]   sb [256];
    logic [31:0]  expw [3][60];

    key_schedule_ctrl #(.Nk(4)) u4 (.clk(clk), .rst_n(rst_n), .start(st[0]), .key_in(key[127:0]),
        .busy(busy_o[0]), .done(done_o[0]), .key_valid(kv_o[0]), .rk_rd_idx(idx), .rk_rd_data(rd_o[0]));
    key_schedule_ctrl #(.Nk(6)) u6 (.clk(clk), .rst_n(rst_n), .start(st[1]), .key_in(key[191:0]),
        .busy(busy_o[1]), .done(done_o[1]), .key_valid(kv_o[1]), .rk_rd_idx(idx), .rk_rd_data(rd_o[1]));
    key_schedule_ctrl #(.Nk(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st[2]), .key_in(key),
        .busy(busy_o[2]), .done(done_o[2]), .key_valid(kv_o[2]), .rk_rd_idx(idx), .rk_rd_data(rd_o[2]));

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_vld <= rd_req;
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic int gfm(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= a << i;
        for (int k = 14; k >= 8; k--) if (p[k]) p ^= 'h11b << (k - 8);
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [255:0] fips(input logic [255:0] v, input int nb);
        logic [255:0] r = '0;
        for (int n = 0; n < nb; n++) r[8*n +: 8] = v[8*(nb-1-n) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] f128(input logic [127:0] v);
        logic [255:0] t = fips({128'h0, v}, 16);
        return t[127:0];
    endfunction

    function automatic logic [255:0] rnd_key();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) if (gfm(x, y) == 1) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    task automatic build_ref(input int s, input logic [255:0] k);
        int nk = NKS[s];
        int nw = 4 * (nk + 7);
        int rc = 1;
        logic [31:0] t;
        for (int i = 0; i < 60; i++) expw[s][i] = '0;
        for (int i = 0; i < nk; i++) expw[s][i] = k[32*i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = expw[s][i-1];
            if (i % nk == 0) begin
                t = subw({t[7:0], t[31:8]}) ^ 32'(rc);
                rc = gfm(rc, 2);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            expw[s][i] = expw[s][i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_of(input int s, input int i);
        logic [127:0] r = '0;
        if (i <= NRS[s]) for (int j = 0; j < 4; j++) r[32*j +: 32] = expw[s][4*i+j];
        return r;
    endfunction

    task automatic do_start(input int s, input logic [255:0] k);
        @(negedge clk);
        key   = k;
        st[s] = 1'b1;
        done_q.push_back('{s, cyc + SS[s] + 2});
        build_ref(s, k);
    endtask

    task automatic run(input int s, input int rp, input logic [255:0] k2);
        int b = 0;
        for (int n = 1; n <= SS[s] + 4; n++) begin
            @(negedge clk);
            st[s] = n == rp;
            if (n == rp) key = k2;
            if (n == 1) chk($sformatf("kv_drop_nk%0d", NKS[s]), 128'(kv_o[s]), 0);
            b += int'(busy_o[s]);
        end
        chk($sformatf("busy_cycles_nk%0d", NKS[s]), 128'(b), 128'(SS[s] + 1));
        chk($sformatf("done_missing_nk%0d", NKS[s]), 128'(done_q.size()), 0);
        chk($sformatf("kv_after_nk%0d", NKS[s]), 128'(kv_o[s]), 1);
    endtask

    task automatic chk_rd(input int s, input int i, input logic [127:0] e);
        @(negedge clk);
        idx    = 4'(i);
        rd_req = 1'b1;
        rd_q.push_back('{s, i, e});
    endtask

    task automatic rd_end();
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic sweep(input int s);
        for (int i = 0; i < 16; i++) chk_rd(s, i, exp_of(s, i));
        rd_end();
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) if (done_o[s]) begin
            if (done_q.size() == 0 || done_q[0].s != s) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done_nk%0d: got done=1 at cycle %0d expected none", NKS[s], cyc);
            end else begin
                dn_t d;
                d = done_q.pop_front();
                chk($sformatf("done_cycle_nk%0d", NKS[s]), 128'(cyc), 128'(d.c));
                chk($sformatf("kv_at_done_nk%0d", NKS[s]), 128'(kv_o[s]), 1);
            end
        end
        if (rd_vld) begin
            rd_t r;
            r = rd_q.pop_front();
            chk($sformatf("rd_nk%0d_idx%0d", NKS[r.s], r.i), rd_o[r.s], r.e);
        end
    end

    initial begin
        logic [255:0] k1, k2;
        build_sbox();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_busy", 128'(busy_o[s]), 0);
            chk("rst_done", 128'(done_o[s]), 0);
            chk("rst_kv", 128'(kv_o[s]), 0);
            chk("rst_rd", rd_o[s], 0);
        end
        rst_n = 1'b1;

        k1 = fips(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
        do_start(0, k1);
        run(0, 0, '0);
        chk_rd(0, 10, f128(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        chk_rd(0, 0, k1[127:0]);
        rd_end();
        sweep(0);

        do_start(1, fips(256'h000102030405060708090a0b0c0d0e0f1011121314151617, 24));
        run(1, 0, '0);
        chk_rd(1, 12, f128(128'ha4970a331a78dc09c418c271e3a41d5d));
        chk_rd(1, 13, '0);
        rd_end();
        sweep(1);

        do_start(2, fips(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 32));
        run(2, 0, '0);
        chk_rd(2, 14, f128(128'h24fc79ccbf0979e9371ac23c6d68de36));
        chk_rd(2, 1, f128(128'h101112131415161718191a1b1c1d1e1f));
        rd_end();
        sweep(2);

        for (int s = 0; s < 3; s++) begin
            do_start(s, rnd_key());
            run(s, 5, rnd_key());
            sweep(s);
        end

        do_start(1, rnd_key());
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            st[1] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy_o[1]), 0);
        chk("midrst_done", 128'(done_o[1]), 0);
        chk("midrst_rd", rd_o[1], 0);
        chk("midrst_kv4", 128'(kv_o[0]), 0);
        done_q.delete();
        for (int s = 0; s < 3; s++) for (int i = 0; i < 60; i++) expw[s][i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk_rd(0, 3, '0);
        chk_rd(1, 2, '0);
        rd_end();
        do_start(1, rnd_key());
        run(1, 0, '0);
        sweep(1);

        do_start(0, rnd_key());
        for (int n = 1; n <= SS[0] + 2; n++) begin
            @(negedge clk);
            st[0] = 1'b0;
        end
        chk("b2b_kv_first", 128'(kv_o[0]), 1);
        k2 = rnd_key();
        do_start(0, k2);
        run(0, 0, '0);
        chk_rd(0, 10, exp_of(0, 10));
        rd_end();
        sweep(0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
